// File: rtl/gb_write_ctrl.sv
// ---------------------------------------------------------------------------
// gb_write_ctrl
// Responder side of the global-buffer write-request protocol. Takes the
// registered Wr_Req/Wr_ID pair from the write arbiter, reports its state on
// State_Wr, grants the requesting class and accepts a burst of BURST_LEN data
// beats. The beats are written into the addressed GB bank. Each of the 16
// banks has its own write pointer.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   Wr_Req       request from arbiter (looked at only in IDLE)
//   Wr_ID        [5:4] requester class, [3:0] target bank
//   State_Wr     IDLE=00, REQ_READY=01, READY_TO_WRITE=11, WRITE=10
//   Wr_Gnt       one-hot class grant, single-cycle pulse in REQ_READY
//   Wr_Rdy       beat accepted this cycle if Wr_Dat_Vld is also high
//   Wr_Dat       write data beat
//   Wr_Dat_Vld   beat valid
//   Clr_Ptr      clear all bank write pointers (deferred until IDLE)
//   Sram_WEn     one-hot bank write enable, one cycle after beat acceptance
//   Sram_Addr    bank word address
//   Sram_Dat     bank write data
//   Wr_Done      single-cycle pulse together with the last SRAM write of a burst
//   Wr_Done_ID   ID of the completed burst, valid with Wr_Done
//   Err_Ovf      sticky: beat offered while Wr_Rdy was low
// ---------------------------------------------------------------------------
module gb_write_ctrl #(
    parameter int DATA_W    = 128,
    parameter int ADDR_W    = 8,
    parameter int BURST_LEN = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Wr_Req,
    input  logic [5:0]        Wr_ID,
    output logic [1:0]        State_Wr,
    output logic [3:0]        Wr_Gnt,
    output logic              Wr_Rdy,
    input  logic [DATA_W-1:0] Wr_Dat,
    input  logic              Wr_Dat_Vld,
    input  logic              Clr_Ptr,
    output logic [15:0]       Sram_WEn,
    output logic [ADDR_W-1:0] Sram_Addr,
    output logic [DATA_W-1:0] Sram_Dat,
    output logic              Wr_Done,
    output logic [5:0]        Wr_Done_ID,
    output logic              Err_Ovf
);

    typedef enum logic [1:0] {
        IDLE           = 2'b00,
        REQ_READY      = 2'b01,
        READY_TO_WRITE = 2'b11,
        WRITE          = 2'b10
    } state_t;

    localparam int CNT_W = $clog2(BURST_LEN + 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [5:0]        id_q, id_d;
    logic [ADDR_W-1:0] ptr_q [16];
    logic              clr_pend_q;

    logic              beat_acc;
    logic              last_beat;
    logic              clr_now;
    logic [3:0]        bank;

    assign State_Wr  = state_q;
    assign Wr_Rdy    = (state_q == READY_TO_WRITE) || (state_q == WRITE);
    assign beat_acc  = Wr_Rdy & Wr_Dat_Vld;
    // cnt_q counts beats already taken, so this beat completes the burst.
    assign last_beat = beat_acc && (cnt_q == CNT_W'(BURST_LEN - 1));
    // A clear arriving mid-burst is held back so the current burst keeps
    // using the addresses it started with.
    assign clr_now   = (state_q == IDLE) && (Clr_Ptr || clr_pend_q);
    assign bank      = id_q[3:0];

    always_comb begin
        Wr_Gnt = '0;
        if (state_q == REQ_READY) begin
            Wr_Gnt[id_q[5:4]] = 1'b1;
        end
    end

    // NOTE: every output of this block gets a default value first. Then no
    // path through the case leaves a signal unassigned, and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (Wr_Req) begin
                    id_d    = Wr_ID;
                    state_d = REQ_READY;
                end
            end
            REQ_READY: state_d = READY_TO_WRITE;
            READY_TO_WRITE, WRITE: begin
                if (last_beat) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (beat_acc) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = WRITE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples values from before the edge, whatever order
    // the statements are in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            id_q       <= '0;
            clr_pend_q <= 1'b0;
            Err_Ovf    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            if (clr_now) begin
                clr_pend_q <= 1'b0;
            end else if (Clr_Ptr) begin
                clr_pend_q <= 1'b1;
            end
            if (Wr_Dat_Vld && !Wr_Rdy) begin
                Err_Ovf <= 1'b1;
            end
        end
    end

    // NOTE: the pointer array gets an explicit reset. It is a small register
    // file, not SRAM, and every burst after a reset must start at address 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 16; b++) begin
                ptr_q[b] <= '0;
            end
        end else if (clr_now) begin
            // Beats are never accepted in IDLE, so a clear cannot collide
            // with a pointer increment.
            for (int b = 0; b < 16; b++) begin
                ptr_q[b] <= '0;
            end
        end else if (beat_acc) begin
            ptr_q[bank] <= ptr_q[bank] + ADDR_W'(1);
        end
    end

    // The SRAM port is registered. A beat accepted in cycle t is written
    // in cycle t+1, at the pointer value from before the increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Sram_WEn   <= '0;
            Sram_Addr  <= '0;
            Sram_Dat   <= '0;
            Wr_Done    <= 1'b0;
            Wr_Done_ID <= '0;
        end else begin
            Sram_WEn <= '0;
            Wr_Done  <= 1'b0;
            if (beat_acc) begin
                Sram_WEn  <= 16'(1) << bank;
                Sram_Addr <= ptr_q[bank];
                Sram_Dat  <= Wr_Dat;
            end
            if (last_beat) begin
                Wr_Done    <= 1'b1;
                Wr_Done_ID <= id_q;
            end
        end
    end

endmodule

// File: tb/tb_gb_write_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gb_write_ctrl
// Scoreboard bench for gb_write_ctrl. The stimulus process runs bursts. For
// each accepted beat it pushes the expected SRAM write, computed from a
// per-bank pointer array. For each request it pushes the expected grant. A
// separate monitor samples on the falling edge. It pops an entry and compares
// whenever the DUT presents a write or a grant.
// ---------------------------------------------------------------------------
module tb_gb_write_ctrl;

    localparam int DATA_W    = 128;
    localparam int ADDR_W    = 8;
    localparam int BURST_LEN = 16;
    localparam int DEPTH     = 1 << ADDR_W;

    logic              clk;
    logic              rst_n;
    logic              Wr_Req;
    logic [5:0]        Wr_ID;
    logic [1:0]        State_Wr;
    logic [3:0]        Wr_Gnt;
    logic              Wr_Rdy;
    logic [DATA_W-1:0] Wr_Dat;
    logic              Wr_Dat_Vld;
    logic              Clr_Ptr;
    logic [15:0]       Sram_WEn;
    logic [ADDR_W-1:0] Sram_Addr;
    logic [DATA_W-1:0] Sram_Dat;
    logic              Wr_Done;
    logic [5:0]        Wr_Done_ID;
    logic              Err_Ovf;

    gb_write_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN)) dut (
        .clk(clk), .rst_n(rst_n), .Wr_Req(Wr_Req), .Wr_ID(Wr_ID),
        .State_Wr(State_Wr), .Wr_Gnt(Wr_Gnt), .Wr_Rdy(Wr_Rdy),
        .Wr_Dat(Wr_Dat), .Wr_Dat_Vld(Wr_Dat_Vld), .Clr_Ptr(Clr_Ptr),
        .Sram_WEn(Sram_WEn), .Sram_Addr(Sram_Addr), .Sram_Dat(Sram_Dat),
        .Wr_Done(Wr_Done), .Wr_Done_ID(Wr_Done_ID), .Err_Ovf(Err_Ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]       wen;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] dat;
        logic              done;
        logic [5:0]        id;
    } wr_t;

    wr_t         wr_q[$];
    logic [3:0]  gnt_q[$];
    int unsigned model_ptr[16];
    bit          model_pend;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string detail);
        n_vec++;
        n_err++;
        $display("FAIL %s: %s", name, detail);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int b = 0; b < 16; b++) model_ptr[b] = 0;
        model_pend = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, State_Wr, 2'b00);
        check({tag, "_gnt"},   Wr_Gnt, 4'b0);
        check({tag, "_rdy"},   Wr_Rdy, 1'b0);
        check({tag, "_wen"},   Sram_WEn, 16'b0);
        check({tag, "_addr"},  Sram_Addr, '0);
        check({tag, "_dat"},   Sram_Dat, '0);
        check({tag, "_done"},  Wr_Done, 1'b0);
        check({tag, "_did"},   Wr_Done_ID, 6'b0);
        check({tag, "_ovf"},   Err_Ovf, 1'b0);
    endtask

    // gap_mode: 0 = back-to-back beats, 1 = valid toggles every cycle,
    // 2 = random gaps. clr_beat / rst_beat: beat number (1-based) at which
    // Clr_Ptr is pulsed or reset is asserted; 0 means never.
    task automatic burst(input logic [5:0] id, input bit clr_req, input int gap_mode,
                         input int clr_beat, input int rst_beat);
        int  budget;
        wr_t e;
        budget = 0;
        while (State_Wr !== 2'b00 && budget < 50) begin
            step();
            budget++;
        end
        if (State_Wr !== 2'b00) begin
            fail_now("wait_idle", $sformatf("State_Wr stuck at %b, required 00", State_Wr));
            return;
        end
        Wr_Req  = 1'b1;
        Wr_ID   = id;
        Clr_Ptr = clr_req;
        if (clr_req || model_pend) model_clear();
        gnt_q.push_back(4'b0001 << id[5:4]);
        step();
        Wr_Req  = 1'b0;
        Clr_Ptr = 1'b0;
        check("state_req", State_Wr, 2'b01);
        budget = 0;
        while (!Wr_Rdy && budget < 4) begin
            step();
            budget++;
        end
        if (!Wr_Rdy) begin
            fail_now("wait_rdy", "Wr_Rdy stayed 0, required 1");
            return;
        end
        check("state_rtw", State_Wr, 2'b11);
        for (int b = 1; b <= BURST_LEN; b++) begin
            if (b > 1 && (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 3) == 0))) begin
                Wr_Dat_Vld = 1'b0;
                step();
            end
            Wr_Dat     = {$urandom, $urandom, $urandom, $urandom};
            Wr_Dat_Vld = 1'b1;
            if (b == rst_beat) begin
                @(negedge clk);
                #1;
                rst_n      = 1'b0;
                Wr_Dat_Vld = 1'b0;
                return;
            end
            if (b == clr_beat) begin
                Clr_Ptr    = 1'b1;
                model_pend = 1'b1;
            end
            e.wen  = 16'(1) << id[3:0];
            e.addr = ADDR_W'(model_ptr[id[3:0]]);
            e.dat  = Wr_Dat;
            e.done = (b == BURST_LEN);
            e.id   = id;
            wr_q.push_back(e);
            model_ptr[id[3:0]] = (model_ptr[id[3:0]] + 1) % DEPTH;
            step();
            Clr_Ptr = 1'b0;
        end
        Wr_Dat_Vld = 1'b0;
        check("state_end", State_Wr, 2'b00);
    endtask

    // Monitor: compares every SRAM write and every grant against the queues.
    initial begin
        wr_t e;
        logic [3:0] g;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (Sram_WEn != 16'b0 || Wr_Done) begin
                    if (wr_q.size() == 0) begin
                        fail_now("extra_write", $sformatf("WEn=%h Done=%b, required no write",
                                                          Sram_WEn, Wr_Done));
                    end else begin
                        e = wr_q.pop_front();
                        check("wr_wen",  Sram_WEn, e.wen);
                        check("wr_addr", Sram_Addr, e.addr);
                        check("wr_dat",  Sram_Dat, e.dat);
                        check("wr_done", Wr_Done, e.done);
                        if (e.done) check("wr_done_id", Wr_Done_ID, e.id);
                    end
                end
                if (Wr_Gnt != 4'b0) begin
                    if (gnt_q.size() == 0) begin
                        fail_now("extra_gnt", $sformatf("Wr_Gnt=%b, required 0000", Wr_Gnt));
                    end else begin
                        g = gnt_q.pop_front();
                        check("gnt", Wr_Gnt, g);
                        check("gnt_state", State_Wr, 2'b01);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

    initial begin
        logic [5:0] rid;
        rst_n      = 1'b0;
        Wr_Req     = 1'b0;
        Wr_ID      = '0;
        Wr_Dat     = '0;
        Wr_Dat_Vld = 1'b0;
        Clr_Ptr    = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        step();

        // Basic bursts, then independent bank pointers.
        burst(6'h25, 1'b0, 0, 0, 0);
        burst(6'h25, 1'b0, 0, 0, 0);
        burst(6'h05, 1'b0, 0, 0, 0);
        // Valid toggling every cycle.
        burst(6'h25, 1'b0, 1, 0, 0);
        // Enough bursts to one bank to wrap its pointer past 2**ADDR_W.
        for (int i = 0; i < DEPTH / BURST_LEN + 1; i++) burst(6'h33, 1'b0, 0, 0, 0);
        // Clear mid-burst is deferred; a clear with the request starts at 0.
        burst(6'h25, 1'b0, 0, 5, 0);
        burst(6'h25, 1'b0, 0, 0, 0);
        burst(6'h05, 1'b0, 0, 0, 0);
        burst(6'h12, 1'b1, 0, 0, 0);
        // Randomized traffic.
        for (int i = 0; i < 30; i++) begin
            rid = 6'($urandom);
            burst(rid, ($urandom_range(0, 9) == 0), 2,
                  ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, BURST_LEN)) : 0, 0);
        end
        step();

        // Stray beat in IDLE: sticky error, no write.
        check("ovf_clear", Err_Ovf, 1'b0);
        Wr_Dat_Vld = 1'b1;
        Wr_Dat     = {4{32'hdeadbeef}};
        step();
        Wr_Dat_Vld = 1'b0;
        check("ovf_set", Err_Ovf, 1'b1);
        check("ovf_wen", Sram_WEn, 16'b0);
        repeat (3) step();
        check("ovf_sticky", Err_Ovf, 1'b1);

        // Reset during beat 7 of a burst.
        burst(6'h25, 1'b0, 0, 0, 7);
        #1;
        check_reset_outputs("midrst");
        check("midrst_pending", wr_q.size(), 0);
        model_clear();
        gnt_q.delete();
        wr_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        burst(6'h25, 1'b0, 0, 0, 0);

        repeat (4) step();
        check("wr_q_drained", wr_q.size(), 0);
        check("gnt_q_drained", gnt_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
